cabac_terminate_encode_bin: RTL and testbench
=============================================

// Module: cabac_terminate_encode_bin
// PURPOSE
//  Encoder-side end-of-slice/terminate bin engine for the H.265 CABAC encoder (9.3.4.3.5).
//  Takes arithmetic state from the regular-bin encoder: ivlLow, ivlCurrRange, bitsOutstanding, firstBitFlag.
//  Encodes one terminate bin. For binVal=0: range-=2, then RenormE. For binVal=1: full EncodeFlush.
//  Emits bitstream bits serially over a valid/ready link, then returns the updated state.
// PARAMETERS
//  BO_W  16  width of the bitsOutstanding counter
// PORTS
//  clk                  in   1     clock; all state updates on rising edge
//  rst_n                in   1     asynchronous, active-low reset
//  i_valid              in   1     start request; sampled only when o_ready=1
//  i_binVal             in   1     terminate bin value (1 = end_of_slice/flush)
//  i_ivlLow             in   10    incoming ivlLow
//  i_ivlCurrRange       in   9     incoming ivlCurrRange (256..510)
//  i_bitsOutstanding    in   BO_W  incoming outstanding count
//  i_firstBitFlag       in   1     incoming firstBitFlag
//  o_ready              out  1     idle, accepts i_valid
//  o_bit                out  1     bitstream bit
//  o_bit_valid          out  1     o_bit is valid
//  i_bit_ready          in   1     sink accepts o_bit
//  o_done               out  1     one-cycle pulse; o_* state below is valid
//  o_ivlLow             out  10    updated ivlLow
//  o_ivlCurrRange       out  9     updated ivlCurrRange
//  o_bitsOutstanding    out  BO_W  updated outstanding count
//  o_firstBitFlag       out  1     updated firstBitFlag
//  o_bo_overflow        out  1     sticky flag: bitsOutstanding increment at all-ones
// BEHAVIOUR
//  Reset values:
//   - o_ready=1; o_bit=0, o_bit_valid=0, o_done=0, o_bo_overflow=0.
//   - o_ivlLow=0, o_ivlCurrRange=510, o_bitsOutstanding=0, o_firstBitFlag=1.
//  FSM states: IDLE, RENORM, PUT, FLUSH_PUT, FLUSH_W1, FLUSH_W0, DONE.
//  IDLE:
//   - i_valid & o_ready: latch inputs, range=i_ivlCurrRange-2.
//   - binVal=1: low=i_ivlLow+range, then range=2.
//   - Go to RENORM. o_ready=0 from the next cycle.
//  RENORM (one iteration per cycle, no bit emitted inside the iteration):
//   - range>=256: exit. binVal=0 goes to DONE; binVal=1 goes to FLUSH_PUT.
//   - low<256: pending bit b=0, go to PUT.
//   - low>=512: low-=512, pending b=1, go to PUT.
//   - otherwise: low-=256, bitsOutstanding++.
//   - range<<=1 and low<<=1 (10-bit) are applied in the same cycle as the case decision.
//  PUT (PutBit):
//   - If firstBitFlag: clear it and skip the b bit. Otherwise emit b.
//   - Then emit (1-b) once per outstanding count, decrementing the count.
//   - When finished, return to the caller state (RENORM or FLUSH_W1).
//  FLUSH_PUT: pending b=low[9], enter PUT with return state FLUSH_W1.
//  FLUSH_W1: emit low[8]. FLUSH_W0: emit constant 1, then go to DONE.
//   - Together these write (((low>>7)&3)|1) as 2 bits, MSB first.
//  Bit link:
//   - o_bit_valid stays high and o_bit stays stable until i_bit_ready.
//   - At most 1 bit per cycle; a bit counts as emitted on valid&ready.
//   - i_bit_ready=0 stalls the FSM with no state change.
//  DONE:
//   - o_done=1 for 1 cycle with the o_* state.
//   - After a flush, o_ivlCurrRange=256 and low is the post-renorm value.
//   - Next cycle returns to IDLE.
//  Other boundary rules:
//   - i_valid while busy is ignored.
//   - bitsOutstanding at all-ones on increment: hold the value and set o_bo_overflow (cleared only by reset).
//   - Reset mid-operation: return to IDLE asynchronously with reset values. Partially emitted bits are the sink's concern.
//  Latency, binVal=0 without renorm: accept cycle -> RENORM(exit) -> DONE, i.e. o_done 2 cycles after accept.
// STRUCTURE
//  Shared package (defines.v): CABAC_RANGE_INIT=510, CABAC_QUARTER=256, CABAC_HALF=512, FSM state encodings.
//  Sub-module cabac_put_bit_ctrl: owns the firstBitFlag/outstanding emit loop and the valid/ready bit link.
//   - Start/done handshake with the parent FSM.
//   - The same sub-module is reused by the regular/bypass bin encoders.
// TESTING
//  1 low=0, range=510, fbf=1, bo=0, bin=0
//    -> no bits; o_done 2 cycles after accept; range=508, low=0, bo=0, fbf=1.
//  2 low=0, range=257, fbf=1, bin=0
//    -> range 255, 1 renorm with PutBit(0) suppressed by fbf; no bits; range=510, low=0, fbf=0.
//  3 flush: low=0, range=510, fbf=1, bo=0, bin=1
//    -> 7 renorm steps give bo=7, low=0; first bit suppressed; bits 1111111 then 0,1 (9 bits).
//    -> final range=256, low=0, bo=0, fbf=0.
//  4 Repeat 3 with fbf=0 and i_bit_ready toggling 1010...
//    -> bits 0 1111111 0 1 (10 bits); o_bit held stable in every stalled cycle; same final state.
//  5 Assert rst_n low in the middle of 3's bit burst
//    -> immediately o_bit_valid=0, o_ready=1, reset state values; a new request then completes normally.
//  6 bo=2^BO_W-1 with a renorm case low in [256,512)
//    -> o_bo_overflow=1 and stays high; bo held at all-ones.

Source files
------------

// File: rtl/cabac_terminate_encode_bin_pkg.sv
// Shared constants and state encodings for the CABAC terminate-bin encoder
// and its PutBit controller.
package cabac_terminate_encode_bin_pkg;

    localparam logic [8:0] CABAC_RANGE_INIT = 9'd510;
    localparam logic [9:0] CABAC_QUARTER    = 10'd256;
    localparam logic [9:0] CABAC_HALF       = 10'd512;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RENORM    = 3'd1,
        ST_PUT       = 3'd2,
        ST_FLUSH_PUT = 3'd3,
        ST_FLUSH_W1  = 3'd4,
        ST_FLUSH_W0  = 3'd5,
        ST_DONE      = 3'd6
    } te_state_e;

    typedef enum logic [1:0] {
        PB_IDLE  = 2'd0,
        PB_FIRST = 2'd1,
        PB_OUTS  = 2'd2
    } pb_state_e;

endpackage

// File: rtl/cabac_terminate_encode_bin_put_bit_ctrl.sv
// cabac_put_bit_ctrl: PutBit engine shared by the CABAC bin encoders.
// Owns firstBitFlag and bitsOutstanding, and drives the serial bit link
// while a PutBit is in progress.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_load            load fbf/bo from i_load_fbf / i_load_bo
//   i_inc_bo          bitsOutstanding++ (saturating, sets sticky overflow)
//   i_start, i_b      start PutBit(b); accepted only when idle
//   o_busy            PutBit in progress (link owned by this block)
//   o_done            one-cycle pulse, PutBit finished this cycle
//   o_bit, o_bit_valid, i_bit_ready   serial bit link
//   o_fbf, o_bo, o_bo_overflow        current flag/counter/overflow state
module cabac_put_bit_ctrl
    import cabac_terminate_encode_bin_pkg::*;
#(
    parameter int BO_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_load_fbf,
    input  logic [BO_W-1:0] i_load_bo,
    input  logic            i_inc_bo,
    input  logic            i_start,
    input  logic            i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_bit,
    output logic            o_bit_valid,
    input  logic            i_bit_ready,
    output logic            o_fbf,
    output logic [BO_W-1:0] o_bo,
    output logic            o_bo_overflow
);

    localparam logic [BO_W-1:0] BO_ONE = {{(BO_W-1){1'b0}}, 1'b1};

    pb_state_e       state_q, state_d;
    logic            b_q, b_d;
    logic            fbf_q, fbf_d;
    logic [BO_W-1:0] bo_q, bo_d;
    logic            ovf_q, ovf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PB_IDLE;
            b_q     <= 1'b0;
            fbf_q   <= 1'b1;
            bo_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            fbf_q   <= fbf_d;
            bo_q    <= bo_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        b_d         = b_q;
        fbf_d       = fbf_q;
        bo_d        = bo_q;
        ovf_d       = ovf_q;
        o_bit       = 1'b0;
        o_bit_valid = 1'b0;
        o_done      = 1'b0;

        if (i_load) begin
            fbf_d = i_load_fbf;
            bo_d  = i_load_bo;
        end

        // Saturate at all-ones rather than wrapping; the overflow is sticky.
        if (i_inc_bo) begin
            if (&bo_q) begin
                ovf_d = 1'b1;
            end else begin
                bo_d = bo_q + BO_ONE;
            end
        end

        case (state_q)
            PB_IDLE: begin
                if (i_start) begin
                    b_d = i_b;
                    // The very first bit of a slice is never written.
                    if (fbf_q) begin
                        fbf_d   = 1'b0;
                        state_d = PB_OUTS;
                    end else begin
                        state_d = PB_FIRST;
                    end
                end
            end
            PB_FIRST: begin
                o_bit_valid = 1'b1;
                o_bit       = b_q;
                if (i_bit_ready) begin
                    state_d = PB_OUTS;
                end
            end
            PB_OUTS: begin
                if (bo_q == '0) begin
                    o_done  = 1'b1;
                    state_d = PB_IDLE;
                end else begin
                    o_bit_valid = 1'b1;
                    o_bit       = ~b_q;
                    if (i_bit_ready) begin
                        bo_d = bo_q - BO_ONE;
                    end
                end
            end
            default: state_d = PB_IDLE;
        endcase
    end

    assign o_busy        = (state_q != PB_IDLE);
    assign o_fbf         = fbf_q;
    assign o_bo          = bo_q;
    assign o_bo_overflow = ovf_q;

endmodule

// File: rtl/cabac_terminate_encode_bin.sv
// cabac_terminate_encode_bin: encodes one CABAC terminate bin.
// binVal=0: range-=2 then renormalise. binVal=1: full flush (range=2,
// renormalise, PutBit(low[9]), then write low[8] and a trailing 1).
// Bits leave serially on a valid/ready link; the updated arithmetic state
// is presented on o_* and qualified by a one-cycle o_done.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   i_valid / o_ready                 start handshake
//   i_binVal, i_ivlLow, i_ivlCurrRange, i_bitsOutstanding, i_firstBitFlag
//                                     incoming bin and arithmetic state
//   o_bit, o_bit_valid, i_bit_ready   serial bitstream link
//   o_done                            result strobe
//   o_ivlLow, o_ivlCurrRange, o_bitsOutstanding, o_firstBitFlag
//                                     updated arithmetic state
//   o_bo_overflow                     sticky bitsOutstanding saturation flag
module cabac_terminate_encode_bin
    import cabac_terminate_encode_bin_pkg::*;
#(
    parameter int BO_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    input  logic            i_binVal,
    input  logic [9:0]      i_ivlLow,
    input  logic [8:0]      i_ivlCurrRange,
    input  logic [BO_W-1:0] i_bitsOutstanding,
    input  logic            i_firstBitFlag,
    output logic            o_ready,
    output logic            o_bit,
    output logic            o_bit_valid,
    input  logic            i_bit_ready,
    output logic            o_done,
    output logic [9:0]      o_ivlLow,
    output logic [8:0]      o_ivlCurrRange,
    output logic [BO_W-1:0] o_bitsOutstanding,
    output logic            o_firstBitFlag,
    output logic            o_bo_overflow
);

    te_state_e  state_q, state_d;
    logic       bin_q, bin_d;
    logic       ret_flush_q, ret_flush_d;
    logic [9:0] low_q, low_d;
    logic [8:0] range_q, range_d;

    logic       pb_load, pb_inc, pb_start, pb_b;
    logic       pb_busy, pb_done, pb_bit, pb_bit_valid;
    logic       raw_valid, raw_bit;
    logic [8:0] range_m2;
    logic [9:0] low_adj;

    cabac_put_bit_ctrl #(.BO_W(BO_W)) u_put_bit (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (pb_load),
        .i_load_fbf    (i_firstBitFlag),
        .i_load_bo     (i_bitsOutstanding),
        .i_inc_bo      (pb_inc),
        .i_start       (pb_start),
        .i_b           (pb_b),
        .o_busy        (pb_busy),
        .o_done        (pb_done),
        .o_bit         (pb_bit),
        .o_bit_valid   (pb_bit_valid),
        .i_bit_ready   (i_bit_ready),
        .o_fbf         (o_firstBitFlag),
        .o_bo          (o_bitsOutstanding),
        .o_bo_overflow (o_bo_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bin_q       <= 1'b0;
            ret_flush_q <= 1'b0;
            low_q       <= '0;
            range_q     <= CABAC_RANGE_INIT;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            ret_flush_q <= ret_flush_d;
            low_q       <= low_d;
            range_q     <= range_d;
        end
    end

    assign range_m2 = i_ivlCurrRange - 9'd2;

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        ret_flush_d = ret_flush_q;
        low_d       = low_q;
        range_d     = range_q;
        pb_load     = 1'b0;
        pb_inc      = 1'b0;
        pb_start    = 1'b0;
        pb_b        = 1'b0;
        raw_valid   = 1'b0;
        raw_bit     = 1'b0;
        low_adj     = low_q;

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    bin_d   = i_binVal;
                    pb_load = 1'b1;
                    if (i_binVal) begin
                        low_d   = i_ivlLow + {1'b0, range_m2};
                        range_d = 9'd2;
                    end else begin
                        low_d   = i_ivlLow;
                        range_d = range_m2;
                    end
                    state_d = ST_RENORM;
                end
            end
            ST_RENORM: begin
                if (range_q[8]) begin
                    state_d = bin_q ? ST_FLUSH_PUT : ST_DONE;
                end else begin
                    ret_flush_d = 1'b0;
                    range_d     = {range_q[7:0], 1'b0};
                    if (low_q < CABAC_QUARTER) begin
                        pb_start = 1'b1;
                        pb_b     = 1'b0;
                        state_d  = ST_PUT;
                    end else if (low_q >= CABAC_HALF) begin
                        low_adj  = low_q - CABAC_HALF;
                        pb_start = 1'b1;
                        pb_b     = 1'b1;
                        state_d  = ST_PUT;
                    end else begin
                        low_adj = low_q - CABAC_QUARTER;
                        pb_inc  = 1'b1;
                    end
                    low_d = {low_adj[8:0], 1'b0};
                end
            end
            ST_PUT: begin
                if (pb_done) begin
                    state_d = ret_flush_q ? ST_FLUSH_W1 : ST_RENORM;
                end
            end
            ST_FLUSH_PUT: begin
                pb_start    = 1'b1;
                pb_b        = low_q[9];
                ret_flush_d = 1'b1;
                state_d     = ST_PUT;
            end
            // The two flush tail bits are ((low >> 7) & 3) | 1, MSB first.
            ST_FLUSH_W1: begin
                raw_valid = 1'b1;
                raw_bit   = low_q[8];
                if (i_bit_ready) begin
                    state_d = ST_FLUSH_W0;
                end
            end
            ST_FLUSH_W0: begin
                raw_valid = 1'b1;
                raw_bit   = 1'b1;
                if (i_bit_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // PutBit and the flush tail never overlap, so a simple mux shares the link.
    assign o_bit          = pb_busy ? pb_bit : raw_bit;
    assign o_bit_valid    = pb_bit_valid | raw_valid;
    assign o_ready        = (state_q == ST_IDLE);
    assign o_done         = (state_q == ST_DONE);
    assign o_ivlLow       = low_q;
    assign o_ivlCurrRange = range_q;

endmodule

// File: tb/tb_cabac_terminate_encode_bin.sv
module tb_cabac_terminate_encode_bin;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        i_binVal;
    logic [9:0]  i_ivlLow;
    logic [8:0]  i_ivlCurrRange;
    logic [15:0] i_bitsOutstanding;
    logic        i_firstBitFlag;
    logic        o_ready;
    logic        o_bit;
    logic        o_bit_valid;
    logic        i_bit_ready;
    logic        o_done;
    logic [9:0]  o_ivlLow;
    logic [8:0]  o_ivlCurrRange;
    logic [15:0] o_bitsOutstanding;
    logic        o_firstBitFlag;
    logic        o_bo_overflow;

    int checks   = 0;
    int failures = 0;

    bit exp_q[$];
    int m_low, m_range, m_bo;
    bit m_fbf, m_ovf;

    cabac_terminate_encode_bin #(.BO_W(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_valid           (i_valid),
        .i_binVal          (i_binVal),
        .i_ivlLow          (i_ivlLow),
        .i_ivlCurrRange    (i_ivlCurrRange),
        .i_bitsOutstanding (i_bitsOutstanding),
        .i_firstBitFlag    (i_firstBitFlag),
        .o_ready           (o_ready),
        .o_bit             (o_bit),
        .o_bit_valid       (o_bit_valid),
        .i_bit_ready       (i_bit_ready),
        .o_done            (o_done),
        .o_ivlLow          (o_ivlLow),
        .o_ivlCurrRange    (o_ivlCurrRange),
        .o_bitsOutstanding (o_bitsOutstanding),
        .o_firstBitFlag    (o_firstBitFlag),
        .o_bo_overflow     (o_bo_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference PutBit of the standard encoder.
    task automatic model_put(input bit b, inout bit fbf, inout int bo);
        if (fbf) fbf = 0;
        else exp_q.push_back(b);
        while (bo > 0) begin
            exp_q.push_back(!b);
            bo--;
        end
    endtask

    // Reference terminate-bin encoding; pushes expected bits and sets m_*.
    task automatic model(input bit bin, input int low_i, input int rng_i,
                         input int bo_i, input bit fbf_i);
        int low, rng, bo, v;
        bit fbf;
        low = low_i; rng = rng_i - 2; bo = bo_i; fbf = fbf_i;
        if (bin) begin
            low = (low + rng) & 1023;
            rng = 2;
        end
        while (rng < 256) begin
            if (low < 256) begin
                model_put(1'b0, fbf, bo);
            end else if (low >= 512) begin
                low -= 512;
                model_put(1'b1, fbf, bo);
            end else begin
                low -= 256;
                if (bo == 65535) m_ovf = 1;
                else bo++;
            end
            rng = rng << 1;
            low = (low << 1) & 1023;
        end
        if (bin) begin
            model_put(bit'((low >> 9) & 1), fbf, bo);
            v = ((low >> 7) & 3) | 1;
            exp_q.push_back(bit'((v >> 1) & 1));
            exp_q.push_back(bit'(v & 1));
        end
        m_low = low; m_range = rng; m_bo = bo; m_fbf = fbf;
    endtask

    // Drives one request and services the bit link, popping the scoreboard
    // on every handshake. rmode: 0 ready always, 1 toggling 1010, 2 random.
    task automatic run_txn(input bit bin, input logic [9:0] low, input logic [8:0] rng,
                           input logic [15:0] bo, input bit fbf, input int rmode,
                           input bit keep_valid, input int abort_n,
                           output int done_cyc, output int nbits);
        int  cyc;
        bit  acc, prev_stall, prev_bit, e;
        done_cyc = -1; nbits = 0; acc = 0; prev_stall = 0; prev_bit = 0;
        @(negedge clk);
        i_valid = 1; i_binVal = bin; i_ivlLow = low; i_ivlCurrRange = rng;
        i_bitsOutstanding = bo; i_firstBitFlag = fbf; i_bit_ready = 1;
        for (int w = 0; w < 50 && !acc; w++) begin
            if (o_ready === 1'b1) acc = 1;
            else @(negedge clk);
        end
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL accept: o_ready=%0b required=1", o_ready);
            i_valid = 0;
            return;
        end
        @(posedge clk);
        #1;
        if (keep_valid) begin
            i_binVal = 0; i_ivlLow = 10'd123; i_ivlCurrRange = 9'd300;
            i_bitsOutstanding = 16'd9; i_firstBitFlag = 0;
        end else begin
            i_valid = 0;
        end
        cyc = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            case (rmode)
                0:       i_bit_ready = 1;
                1:       i_bit_ready = (cyc % 2 == 1);
                default: i_bit_ready = 1'($urandom_range(0, 1));
            endcase
            if (prev_stall) begin
                checks++;
                if (o_bit_valid !== 1'b1 || o_bit !== prev_bit) begin
                    failures++;
                    $display("FAIL stall_hold: valid=%0b bit=%0b required valid=1 bit=%0b",
                             o_bit_valid, o_bit, prev_bit);
                end
            end
            if (o_bit_valid === 1'b1 && i_bit_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_bit: got bit %0b, scoreboard empty", o_bit);
                end else begin
                    e = exp_q.pop_front();
                    if (o_bit !== e) begin
                        failures++;
                        $display("FAIL bit[%0d]: got %0b required %0b", nbits, o_bit, e);
                    end
                end
                nbits++;
                if (abort_n > 0 && nbits == abort_n) return;
            end
            prev_stall = (o_bit_valid === 1'b1) && !i_bit_ready;
            prev_bit   = o_bit;
            if (o_done === 1'b1) begin
                done_cyc = cyc;
                i_valid = 0;
                i_bit_ready = 1;
                return;
            end
        end
        checks++; failures++;
        $display("FAIL timeout: no o_done within 3000 cycles");
        i_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; i_valid = 0; i_binVal = 0; i_ivlLow = 0; i_ivlCurrRange = 9'd510;
        i_bitsOutstanding = 0; i_firstBitFlag = 1; i_bit_ready = 1;
        m_ovf = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_ready, o_bit, o_bit_valid, o_done, o_bo_overflow, o_ivlLow, o_ivlCurrRange,
             o_bitsOutstanding, o_firstBitFlag} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd510, 16'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_values: rdy=%0b bit=%0b bv=%0b done=%0b ovf=%0b low=%0d rng=%0d bo=%0d fbf=%0b required 1 0 0 0 0 0 510 0 1",
                     o_ready, o_bit, o_bit_valid, o_done, o_bo_overflow, o_ivlLow,
                     o_ivlCurrRange, o_bitsOutstanding, o_firstBitFlag);
        end
        rst_n = 1;
    endtask

    task automatic test_no_renorm();
        int dc, nb;
        model(0, 0, 510, 0, 1);
        run_txn(0, 10'd0, 9'd510, 16'd0, 1, 0, 0, 0, dc, nb);
        checks++;
        if (dc != 2) begin
            failures++;
            $display("FAIL no_renorm_latency: done at cycle %0d required 2", dc);
        end
        checks++;
        if ({o_ivlLow, o_ivlCurrRange, o_bitsOutstanding, o_firstBitFlag, nb} !==
            {10'd0, 9'd508, 16'd0, 1'b1, 32'd0}) begin
            failures++;
            $display("FAIL no_renorm_state: low=%0d rng=%0d bo=%0d fbf=%0b bits=%0d required 0 508 0 1 0",
                     o_ivlLow, o_ivlCurrRange, o_bitsOutstanding, o_firstBitFlag, nb);
        end
    endtask

    task automatic test_one_renorm();
        int dc, nb;
        model(0, 0, 257, 0, 1);
        run_txn(0, 10'd0, 9'd257, 16'd0, 1, 0, 0, 0, dc, nb);
        checks++;
        if ({o_ivlLow, o_ivlCurrRange, o_firstBitFlag, nb, exp_q.size()} !==
            {10'd0, 9'd510, 1'b0, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL one_renorm: low=%0d rng=%0d fbf=%0b bits=%0d left=%0d required 0 510 0 0 0",
                     o_ivlLow, o_ivlCurrRange, o_firstBitFlag, nb, exp_q.size());
        end
    endtask

    task automatic test_flush(input bit fbf, input int rmode, input int req_bits);
        int dc, nb;
        model(1, 0, 510, 0, fbf);
        run_txn(1, 10'd0, 9'd510, 16'd0, fbf, rmode, 0, 0, dc, nb);
        checks++;
        if (nb != req_bits || exp_q.size() != 0) begin
            failures++;
            $display("FAIL flush_bits: emitted %0d left %0d required %0d and 0", nb, exp_q.size(), req_bits);
        end
        checks++;
        if ({o_ivlLow, o_ivlCurrRange, o_bitsOutstanding, o_firstBitFlag} !==
            {10'd0, 9'd256, 16'd0, 1'b0}) begin
            failures++;
            $display("FAIL flush_state: low=%0d rng=%0d bo=%0d fbf=%0b required 0 256 0 0",
                     o_ivlLow, o_ivlCurrRange, o_bitsOutstanding, o_firstBitFlag);
        end
        exp_q.delete();
    endtask

    task automatic test_overflow();
        int dc, nb;
        model(0, 300, 256, 65535, 0);
        run_txn(0, 10'd300, 9'd256, 16'hFFFF, 0, 0, 0, 0, dc, nb);
        checks++;
        if ({o_bo_overflow, o_bitsOutstanding, o_ivlLow, o_ivlCurrRange} !==
            {1'b1, 16'hFFFF, 10'd88, 9'd508} || m_ovf !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set: ovf=%0b bo=%0d low=%0d rng=%0d required 1 65535 88 508",
                     o_bo_overflow, o_bitsOutstanding, o_ivlLow, o_ivlCurrRange);
        end
        model(0, 0, 510, 0, 1);
        run_txn(0, 10'd0, 9'd510, 16'd0, 1, 0, 0, 0, dc, nb);
        checks++;
        if (o_bo_overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky: ovf=%0b required 1", o_bo_overflow);
        end
    endtask

    task automatic test_reset_mid_burst();
        int dc, nb;
        model(1, 0, 510, 0, 1);
        run_txn(1, 10'd0, 9'd510, 16'd0, 1, 0, 0, 3, dc, nb);
        rst_n = 0;
        #1;
        checks++;
        if ({o_bit_valid, o_ready, o_done, o_bo_overflow, o_ivlLow, o_ivlCurrRange,
             o_bitsOutstanding, o_firstBitFlag} !== {1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 9'd510, 16'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_burst: bv=%0b rdy=%0b done=%0b ovf=%0b low=%0d rng=%0d bo=%0d fbf=%0b required 0 1 0 0 0 510 0 1",
                     o_bit_valid, o_ready, o_done, o_bo_overflow, o_ivlLow, o_ivlCurrRange,
                     o_bitsOutstanding, o_firstBitFlag);
        end
        exp_q.delete();
        m_ovf = 0;
        @(negedge clk);
        rst_n = 1;
        test_flush(1, 0, 9);
    endtask

    task automatic test_busy_ignored();
        int dc, nb;
        model(1, 0, 510, 0, 0);
        run_txn(1, 10'd0, 9'd510, 16'd0, 0, 0, 1, 0, dc, nb);
        checks++;
        if ({o_ivlLow, o_ivlCurrRange, o_bitsOutstanding, o_firstBitFlag, nb, exp_q.size()} !==
            {10'd0, 9'd256, 16'd0, 1'b0, 32'd10, 32'd0}) begin
            failures++;
            $display("FAIL busy_ignored: low=%0d rng=%0d bo=%0d fbf=%0b bits=%0d required 0 256 0 0 10",
                     o_ivlLow, o_ivlCurrRange, o_bitsOutstanding, o_firstBitFlag, nb);
        end
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL busy_ignored_idle: o_ready=%0b required 1", o_ready);
        end
    endtask

    task automatic test_random();
        int dc, nb, low, rng, bo;
        bit bin, fbf;
        for (int t = 0; t < 10; t++) begin
            bin = 1'($urandom_range(0, 1)); fbf = 1'($urandom_range(0, 1));
            low = $urandom_range(0, 1023); rng = $urandom_range(256, 510);
            bo  = $urandom_range(0, 3);
            model(bin, low, rng, bo, fbf);
            run_txn(bin, 10'(low), 9'(rng), 16'(bo), fbf, 2, 0, 0, dc, nb);
            checks++;
            if ({o_ivlLow, o_ivlCurrRange, o_bitsOutstanding, o_firstBitFlag, o_bo_overflow} !==
                {10'(m_low), 9'(m_range), 16'(m_bo), m_fbf, m_ovf} || exp_q.size() != 0) begin
                failures++;
                $display("FAIL random[%0d]: low=%0d rng=%0d bo=%0d fbf=%0b ovf=%0b left=%0d required %0d %0d %0d %0b %0b 0",
                         t, o_ivlLow, o_ivlCurrRange, o_bitsOutstanding, o_firstBitFlag, o_bo_overflow,
                         exp_q.size(), m_low, m_range, m_bo, m_fbf, m_ovf);
            end
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_no_renorm();
        test_one_renorm();
        test_flush(1, 0, 9);
        test_flush(0, 1, 10);
        test_overflow();
        test_reset_mid_burst();
        test_busy_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
